// File: rtl/de_pipeline_reg.sv
// Decode-to-execute pipeline register with bubble (NOP insert) and stall (hold) control.
// Optional bubble counter port E_bubble_cnt is built only when DE_BUBBLE_CNT_EN is defined.

`ifndef IROP
`define IROP 6'h00
`endif
`ifndef IJ
`define IJ 6'h02
`endif
`ifndef IADDI
`define IADDI 6'h08
`endif
`ifndef ILW
`define ILW 6'h23
`endif
`ifndef ISW
`define ISW 6'h2B
`endif
`ifndef RNONE
`define RNONE 5'd0
`endif

module de_pipeline_reg #(
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [5:0]    D_op,
  input  logic [5:0]    D_funct,
  input  logic [DW-1:0] D_valA,
  input  logic [DW-1:0] D_valB,
  input  logic [DW-1:0] D_imm,
  input  logic [DW-1:0] D_pc,
  input  logic [4:0]    D_dstE,
  input  logic [4:0]    D_dstM,
  input  logic          D_valid,
  input  logic          E_bubble,
  input  logic          E_stall,
  output logic [5:0]    E_op,
  output logic [5:0]    E_funct,
  output logic [DW-1:0] E_valA,
  output logic [DW-1:0] E_valB,
  output logic [DW-1:0] E_imm,
  output logic [DW-1:0] E_pc,
  output logic [4:0]    E_dstE,
  output logic [4:0]    E_dstM,
  output logic          E_valid
`ifdef DE_BUBBLE_CNT_EN
  ,
  output logic [31:0]   E_bubble_cnt
`endif
);

  localparam int unsigned OPW  = 6;
  localparam int unsigned REGW = 5;
  localparam int unsigned CNTW = 32;

  typedef enum logic {
    S_NOP   = 1'b0,
    S_VALID = 1'b1
  } state_e;

  typedef struct packed {
    logic [OPW-1:0]  op;
    logic [OPW-1:0]  funct;
    logic [DW-1:0]   val_a;
    logic [DW-1:0]   val_b;
    logic [DW-1:0]   imm;
    logic [DW-1:0]   pc;
    logic [REGW-1:0] dst_e;
    logic [REGW-1:0] dst_m;
  } fields_t;

  state_e  state_q, state_d;
  fields_t fields_q, fields_d;
  fields_t nop_img;

  // NOP image; only the PC differs between bubble (D_pc) and reset (zero).
  always_comb begin
    nop_img       = '0;
    nop_img.op    = `IROP;
    nop_img.dst_e = `RNONE;
    nop_img.dst_m = `RNONE;
  end

  // Priority below reset: bubble > stall > load.
  always_comb begin
    state_d  = state_q;
    fields_d = fields_q;
    if (E_bubble) begin
      fields_d    = nop_img;
      fields_d.pc = D_pc;
      state_d     = S_NOP;
    end else if (E_stall) begin
      fields_d = fields_q;
      state_d  = state_q;
    end else begin
      fields_d.op    = D_op;
      fields_d.funct = D_funct;
      fields_d.val_a = D_valA;
      fields_d.val_b = D_valB;
      fields_d.imm   = D_imm;
      fields_d.pc    = D_pc;
      // Invalid slots must never match in forwarding or load-use checks.
      fields_d.dst_e = D_valid ? D_dstE : `RNONE;
      fields_d.dst_m = D_valid ? D_dstM : `RNONE;
      state_d        = D_valid ? S_VALID : S_NOP;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_NOP;
      fields_q <= nop_img;
    end else begin
      state_q  <= state_d;
      fields_q <= fields_d;
    end
  end

  assign E_op    = fields_q.op;
  assign E_funct = fields_q.funct;
  assign E_valA  = fields_q.val_a;
  assign E_valB  = fields_q.val_b;
  assign E_imm   = fields_q.imm;
  assign E_pc    = fields_q.pc;
  assign E_dstE  = fields_q.dst_e;
  assign E_dstM  = fields_q.dst_m;
  assign E_valid = (state_q == S_VALID);

`ifdef DE_BUBBLE_CNT_EN
  logic [CNTW-1:0] cnt_q, cnt_d;

  // Free-running wrap-around count of bubble cycles, stall or not.
  always_comb begin
    cnt_d = cnt_q;
    if (E_bubble) begin
      cnt_d = cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign E_bubble_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_de_pipeline_reg.sv
// Scoreboard bench for de_pipeline_reg: directed scenarios then random traffic
// checked against a per-edge reference model.

module tb_de_pipeline_reg;

  localparam int unsigned DW = 32;
  localparam logic [5:0] OP_ROP  = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [4:0] R_NONE  = 5'd0;

  typedef struct packed {
    logic [5:0]    op;
    logic [5:0]    funct;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] imm;
    logic [DW-1:0] pc;
    logic [4:0]    de;
    logic [4:0]    dm;
    logic          v;
  } st_t;

  typedef struct packed {
    st_t         s;
    logic [31:0] cnt;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [5:0]    D_op, D_funct, E_op, E_funct;
  logic [DW-1:0] D_valA, D_valB, D_imm, D_pc, E_valA, E_valB, E_imm, E_pc;
  logic [4:0]    D_dstE, D_dstM, E_dstE, E_dstM;
  logic          D_valid, E_bubble, E_stall, E_valid;
`ifdef DE_BUBBLE_CNT_EN
  logic [31:0]   E_bubble_cnt;
`endif

  de_pipeline_reg #(.DW(DW)) dut (
    .clk(clk), .reset(reset),
    .D_op(D_op), .D_funct(D_funct), .D_valA(D_valA), .D_valB(D_valB),
    .D_imm(D_imm), .D_pc(D_pc), .D_dstE(D_dstE), .D_dstM(D_dstM),
    .D_valid(D_valid), .E_bubble(E_bubble), .E_stall(E_stall),
    .E_op(E_op), .E_funct(E_funct), .E_valA(E_valA), .E_valB(E_valB),
    .E_imm(E_imm), .E_pc(E_pc), .E_dstE(E_dstE), .E_dstM(E_dstM),
    .E_valid(E_valid)
`ifdef DE_BUBBLE_CNT_EN
    , .E_bubble_cnt(E_bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  exp_t        sb_q[$];
  st_t         model;
  logic [31:0] model_cnt;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;

  function automatic st_t nop_image(input logic [DW-1:0] pc);
    st_t r;
    r    = '0;
    r.op = OP_ROP;
    r.de = R_NONE;
    r.dm = R_NONE;
    r.pc = pc;
    return r;
  endfunction

  // Architectural behaviour of one clock edge.
  function automatic st_t ref_next(input st_t cur, input logic rst, input logic bub,
                                   input logic stl, input st_t din);
    st_t r;
    if (rst) return nop_image('0);
    if (bub) return nop_image(din.pc);
    if (stl) return cur;
    r = din;
    if (!din.v) begin
      r.de = R_NONE;
      r.dm = R_NONE;
    end
    return r;
  endfunction

  function automatic st_t mk(input logic [5:0] op, input logic [DW-1:0] a,
                             input logic [4:0] de, input logic [4:0] dm, input logic v);
    st_t r;
    r.op    = op;
    r.funct = 6'($urandom);
    r.a     = a;
    r.b     = $urandom;
    r.imm   = $urandom;
    r.pc    = $urandom;
    r.de    = de;
    r.dm    = dm;
    r.v     = v;
    return r;
  endfunction

  function automatic st_t rand_din();
    logic [5:0] ops [5];
    ops = '{OP_ROP, OP_J, OP_ADDI, OP_LW, OP_SW};
    return mk(ops[$urandom_range(0, 4)], $urandom, 5'($urandom), 5'($urandom),
              ($urandom_range(0, 9) < 7));
  endfunction

  task automatic drive(input logic rst, input logic bub, input logic stl, input st_t din);
    exp_t e;
    reset    = rst;
    E_bubble = bub;
    E_stall  = stl;
    D_op     = din.op;
    D_funct  = din.funct;
    D_valA   = din.a;
    D_valB   = din.b;
    D_imm    = din.imm;
    D_pc     = din.pc;
    D_dstE   = din.de;
    D_dstM   = din.dm;
    D_valid  = din.v;
    model = ref_next(model, rst, bub, stl, din);
    if (rst) model_cnt = '0;
    else if (bub) model_cnt = model_cnt + 32'd1;
    e.s   = model;
    e.cnt = model_cnt;
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: every edge produces one registered output image.
  initial begin
    st_t  got;
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        got = '{E_op, E_funct, E_valA, E_valB, E_imm, E_pc, E_dstE, E_dstM, E_valid};
        n_tests++;
        if (got !== e.s) begin
          n_fail++;
          $display("FAIL stage_regs cycle %0d: got op=%h fn=%h a=%h b=%h imm=%h pc=%h de=%h dm=%h v=%b, exp op=%h fn=%h a=%h b=%h imm=%h pc=%h de=%h dm=%h v=%b",
                   cyc, got.op, got.funct, got.a, got.b, got.imm, got.pc, got.de, got.dm, got.v,
                   e.s.op, e.s.funct, e.s.a, e.s.b, e.s.imm, e.s.pc, e.s.de, e.s.dm, e.s.v);
        end
`ifdef DE_BUBBLE_CNT_EN
        n_tests++;
        if (E_bubble_cnt !== e.cnt) begin
          n_fail++;
          $display("FAIL bubble_cnt cycle %0d: got %h exp %h", cyc, E_bubble_cnt, e.cnt);
        end
`endif
      end
    end
  end

  initial begin
    st_t d;
    model     = nop_image('0);
    model_cnt = '0;

    // Reset for two edges, then a load with dstM=7.
    d = mk(OP_LW, 32'h0, 5'd0, 5'b00111, 1'b1);
    drive(1'b1, 1'b0, 1'b0, d);
    drive(1'b1, 1'b0, 1'b0, d);
    drive(1'b0, 1'b0, 1'b0, d);

    // Load, bubble over a valid ADDI, then the ADDI loads.
    drive(1'b0, 1'b0, 1'b0, mk(OP_LW, $urandom, 5'd0, 5'b01011, 1'b1));
    d = mk(OP_ADDI, $urandom, 5'd3, 5'd0, 1'b1);
    drive(1'b0, 1'b1, 1'b0, d);
    drive(1'b0, 1'b0, 1'b0, d);

    // Hold a store through three stall cycles while decode changes.
    drive(1'b0, 1'b0, 1'b0, mk(OP_SW, 32'h1234, 5'd0, 5'd0, 1'b1));
    repeat (3) drive(1'b0, 1'b0, 1'b1, rand_din());
    drive(1'b0, 1'b0, 1'b0, rand_din());

    // Bubble beats stall; reset beats stall.
    drive(1'b0, 1'b1, 1'b1, rand_din());
    drive(1'b0, 1'b0, 1'b0, mk(OP_LW, $urandom, 5'd2, 5'd9, 1'b1));
    drive(1'b0, 1'b0, 1'b1, rand_din());
    drive(1'b1, 1'b0, 1'b1, rand_din());

    // Invalid slot drops its destinations.
    drive(1'b0, 1'b0, 1'b0, mk(OP_ADDI, $urandom, 5'b00100, 5'b00101, 1'b0));

    // Back-to-back bubbles.
    repeat (3) drive(1'b0, 1'b1, 1'b0, rand_din());

`ifdef DE_BUBBLE_CNT_EN
    // Wrap of the bubble counter from a preloaded value.
    force dut.cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.cnt_q;
    model_cnt = 32'hFFFF_FFFE;
    repeat (3) drive(1'b0, 1'b1, 1'b0, rand_din());
`endif

    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 20),
            ($urandom_range(0, 99) < 25), rand_din());
    end

    repeat (3) @(posedge clk);
    #2;
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected outputs never observed, required 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
